// File: rtl/oneway_up_fifo.sv
// oneway_up_fifo: one-way buffered channel from an L1 writer to an L2 reader.
// The writer never stalls and gets no feedback from the reader side. A word
// that arrives while the FIFO is full is dropped, and only the L2-side
// drop_cnt records it. wr_seq depends on wr_valid alone, so nothing the L1
// side can observe is influenced by rd_ready or by occupancy.
module oneway_up_fifo #(
  parameter int DW    = 2,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic [CW-1:0] wr_seq,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic [CW-1:0] drop_cnt
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          push;
  logic          drop;

  // Show-ahead read port driven from registered state only (no write bypass).
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a word
  // if the head is leaving.
  assign pop  = rd_valid & rd_ready;
  assign push = wr_valid & ((count < FULL_CNT) | pop);
  assign drop = wr_valid & (count == FULL_CNT) & ~pop;

  // Storage: written on push only. Contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy update. Reset takes priority over push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Overflow counter, saturating so it never wraps back to a small value.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Writer-side sequence counter. It depends only on wr_valid and wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_seq <= '0;
    end else if (wr_valid) begin
      wr_seq <= wr_seq + 1'b1;
    end
  end

endmodule

// File: tb/tb_oneway_up_fifo.sv
// Testbench for oneway_up_fifo: a directed vector table plus hand-written
// saturation and non-interference sequences.
module tb_oneway_up_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [1:0] wr_data;
  logic [7:0] wr_seq;
  logic       rd_ready;
  logic       rd_valid;
  logic [1:0] rd_data;
  logic [2:0] count;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  oneway_up_fifo #(.DW(2), .DEPTH(4), .AW(2), .CW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_seq   (wr_seq),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wv;
    logic [1:0] wd;
    logic       rr;
    logic       ev;
    logic [1:0] ed;
    logic       cd;
    logic [2:0] ec;
    logic [7:0] edc;
    logic [7:0] es;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic wv, input logic [1:0] wd, input logic rr);
    rst      = r;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] tr_a [200];
  logic [7:0] tr_b [200];
  logic [1:0] q [$];

  task automatic ni_run(input int pat, output logic [7:0] tr [200]);
    logic rr;
    logic wv;
    logic [1:0] wd;
    logic do_pop;
    logic do_push;
    int exp_seq;
    int exp_drop;
    step(1'b1, 1'b0, 2'b00, 1'b0);
    q.delete();
    exp_seq  = 0;
    exp_drop = 0;
    for (int i = 0; i < 200; i++) begin
      wv = (i % 3) != 1;
      wd = 2'(i);
      rr = (pat == 0) ? 1'($urandom_range(0, 1)) : 1'(($urandom_range(0, 3)) == 0);
      do_pop  = (q.size() != 0) && rr;
      do_push = wv && ((q.size() < 4) || do_pop);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(wd);
      if (wv) exp_seq = (exp_seq + 1) % 256;
      if (wv && !do_push && exp_drop < 255) exp_drop++;
      step(1'b0, wv, wd, rr);
      tr[i] = wr_seq;
      check("ni_count", int'(count), q.size());
      check("ni_valid", int'(rd_valid), int'(q.size() != 0));
      if (q.size() != 0) check("ni_data", int'(rd_data), int'(q[0]));
      check("ni_drop", int'(drop_cnt), exp_drop);
      check("ni_seq_model", int'(wr_seq), exp_seq);
    end
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = 2'b00; rd_ready = 1'b0;

    //            rst wv wd     rr   ev ed     cd ec  edc es
    tbl[0]  = '{1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 8'd0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 8'd0, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 2'd1, 1'b1, 3'd1, 8'd0, 8'd1};
    tbl[3]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 2'd1, 1'b1, 3'd2, 8'd0, 8'd2};
    tbl[4]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 2'd1, 1'b1, 3'd3, 8'd0, 8'd3};
    tbl[5]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 1'b1, 3'd2, 8'd0, 8'd3};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 1'b1, 3'd1, 8'd0, 8'd3};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 8'd0, 8'd3};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 8'd0, 8'd3};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 8'd0, 8'd0};
    tbl[10] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 2'd1, 1'b1, 3'd1, 8'd0, 8'd1};
    tbl[11] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 2'd1, 1'b1, 3'd2, 8'd0, 8'd2};
    tbl[12] = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 1'b1, 3'd3, 8'd0, 8'd3};
    tbl[13] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 2'd1, 1'b1, 3'd4, 8'd0, 8'd4};
    tbl[14] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 2'd1, 1'b1, 3'd4, 8'd1, 8'd5};
    tbl[15] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 2'd2, 1'b1, 3'd4, 8'd1, 8'd6};
    tbl[16] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b1, 3'd3, 8'd1, 8'd6};
    tbl[17] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 1'b1, 3'd2, 8'd1, 8'd6};
    tbl[18] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 1'b1, 3'd1, 8'd1, 8'd6};
    tbl[19] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 8'd1, 8'd6};
    tbl[20] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 2'd3, 1'b1, 3'd1, 8'd1, 8'd7};
    tbl[21] = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 8'd0, 8'd0};

    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].rst, tbl[i].wv, tbl[i].wd, tbl[i].rr);
      check($sformatf("v%0d_valid", i), int'(rd_valid), int'(tbl[i].ev));
      check($sformatf("v%0d_count", i), int'(count), int'(tbl[i].ec));
      check($sformatf("v%0d_drop", i), int'(drop_cnt), int'(tbl[i].edc));
      check($sformatf("v%0d_seq", i), int'(wr_seq), int'(tbl[i].es));
      if (tbl[i].cd) check($sformatf("v%0d_data", i), int'(rd_data), int'(tbl[i].ed));
    end

    // Saturation and wrap: 300 write cycles in total, 296 of them into a full FIFO.
    step(1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 2'(i), 1'b0);
    end
    check("sat_drop", int'(drop_cnt), 255);
    check("sat_seq", int'(wr_seq), 44);
    check("sat_count", int'(count), 4);
    check("sat_head", int'(rd_data), 0);

    // Non-interference: same writer stimulus, two different reader patterns.
    ni_run(0, tr_a);
    ni_run(1, tr_b);
    for (int i = 0; i < 200; i++) begin
      check($sformatf("ni_trace%0d", i), int'(tr_b[i]), int'(tr_a[i]));
    end

    // Reset in the middle of a run clears occupancy on the next cycle.
    step(1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b1, 1'b1, 2'd3, 1'b0);
    check("midrst_count", int'(count), 0);
    check("midrst_valid", int'(rd_valid), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
